// File: rtl/mips_encode.sv
// mips_encode: packs field-level requests into MIPS words streamed with byte addresses over valid/ready.
// Define ENC_PSEUDO_LI_EN to expand the LI pseudo-instruction into ori, lui or a lui/ori pair.
module mips_encode #(
  parameter logic [31:0] RESET_ADDR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [5:0]  req_op,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_addr,
  output logic        enc_err,
  output logic [15:0] word_count
);
  typedef enum logic [1:0] {IDLE, HOLD, HOLD_LI} state_t;
  state_t state_q, state_d;
  logic [31:0] word_q, word_d, addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic err_q, err_d;
  logic [31:0] enc_w;
  logic enc_ok, accept, xfer;
  logic unused_imm;
`ifdef ENC_PSEUDO_LI_EN
  logic [31:0] ori_q, ori_d, enc_ori;
  logic enc_two;
`endif
  assign unused_imm = ^req_imm[31:28];
  assign inst_valid = state_q != IDLE;
  assign req_ready = state_q == IDLE || (state_q == HOLD && inst_ready);
  assign accept = req_valid & req_ready;
  assign xfer = inst_valid & inst_ready;
  assign inst_word = word_q;
  assign inst_addr = addr_q;
  assign enc_err = err_q;
  assign word_count = count_q;
  always_comb begin
    enc_w = 32'h0;
    enc_ok = 1'b1;
`ifdef ENC_PSEUDO_LI_EN
    enc_two = 1'b0;
    enc_ori = {6'h0D, req_rt, req_rt, req_imm[15:0]};
`endif
    case (req_kind)
      3'd0: enc_w = {6'h00, req_rs, req_rt, req_rd, 5'd0, req_op};
      3'd1: enc_w = {6'h00, 5'd0, req_rt, req_rd, req_shamt, req_op};
      3'd2: enc_w = {req_op, req_rs, req_rt, req_imm[15:0]};
      3'd3: enc_w = {6'h01, req_rs, req_op[4:0], req_imm[15:0]};
      3'd4: enc_w = {req_op, req_imm[27:2]};
`ifdef ENC_PSEUDO_LI_EN
      // A lone ori covers small constants; otherwise lui leads, with ori only if the low half is nonzero
      3'd5: begin
        enc_w = req_imm[31:16] == 16'h0 ? {6'h0D, 5'd0, req_rt, req_imm[15:0]}
                                        : {6'h0F, 5'd0, req_rt, req_imm[31:16]};
        enc_two = req_imm[31:16] != 16'h0 && req_imm[15:0] != 16'h0;
      end
`endif
      default: enc_ok = 1'b0;
    endcase
  end
  always_comb begin
    state_d = xfer ? IDLE : state_q;
    word_d = word_q;
    addr_d = xfer ? addr_q + 32'd4 : addr_q;
    count_d = xfer && count_q != 16'hFFFF ? count_q + 16'd1 : count_q;
    err_d = accept & ~enc_ok;
`ifdef ENC_PSEUDO_LI_EN
    ori_d = ori_q;
    if (state_q == HOLD_LI && xfer) begin
      state_d = HOLD;
      word_d = ori_q;
    end
`endif
    if (accept && enc_ok) begin
      state_d = HOLD;
      word_d = enc_w;
`ifdef ENC_PSEUDO_LI_EN
      if (enc_two) begin
        state_d = HOLD_LI;
        ori_d = enc_ori;
      end
`endif
    end
    if (start) begin
      state_d = IDLE;
      addr_d = start_addr & ~32'd3;
      count_d = 16'h0;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q <= 32'h0;
      addr_q <= RESET_ADDR;
      count_q <= 16'h0;
      err_q <= 1'b0;
`ifdef ENC_PSEUDO_LI_EN
      ori_q <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      addr_q <= addr_d;
      count_q <= count_d;
      err_q <= err_d;
`ifdef ENC_PSEUDO_LI_EN
      ori_q <= ori_d;
`endif
    end
  end
endmodule
